// File: rtl/trace_trig_seq.sv
// Trace trigger sequencer: arm -> decoder resync -> wait for sync -> armed matching with
// holdoff and trigger limit, plus per-rule saturating match counters.
module trace_trig_seq #(
    parameter int pMATCH_RULES   = 8,
    parameter int pCOUNT_WIDTH   = 8,
    parameter int pTIMEOUT_WIDTH = 16
) (
    input  logic                                 trace_clk,
    input  logic                                 reset_n,
    input  logic                                 I_arm,
    input  logic                                 I_disarm,
    input  logic [pMATCH_RULES-1:0]              I_pattern_enable,
    input  logic                                 I_trig_toggle,
    input  logic [15:0]                          I_holdoff,
    input  logic [7:0]                           I_trig_limit,
    input  logic                                 I_synchronized,
    input  logic [pMATCH_RULES-1:0]              I_matching_pattern,
    output logic                                 O_trace_reset_sync,
    output logic                                 O_trace_trig_enable,
    output logic                                 O_trig,
    output logic [pMATCH_RULES*pCOUNT_WIDTH-1:0] O_trace_count,
    output logic [2:0]                           O_state,
    output logic                                 O_sync_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESYNC    = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_ARMED     = 3'd3,
        ST_HOLDOFF   = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam logic [pCOUNT_WIDTH-1:0]   CNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pTIMEOUT_WIDTH-1:0] TO_ONE  = {{(pTIMEOUT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [pCOUNT_WIDTH-1:0] sat_inc(input logic [pCOUNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t                                   state_q, state_d;
    logic [1:0]                               rs_cnt_q, rs_cnt_d;
    logic [pTIMEOUT_WIDTH-1:0]                to_cnt_q, to_cnt_d;
    logic [15:0]                              ho_cnt_q, ho_cnt_d;
    logic [7:0]                               fire_cnt_q, fire_cnt_d;
    logic                                     trig_q, trig_d;
    logic                                     reset_sync_q, reset_sync_d;
    logic                                     trig_en_q, trig_en_d;
    logic                                     sync_to_q, sync_to_d;
    logic [pMATCH_RULES-1:0][pCOUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                                     hit_s;
    logic                                     arm_ok_s;
    logic                                     fire_s;
    logic                                     clear_s;
    logic                                     count_en_s;
    logic [7:0]                               fire_next_s;
    logic [pTIMEOUT_WIDTH-1:0]                to_next_s;

    assign hit_s       = |(I_matching_pattern & I_pattern_enable);
    assign arm_ok_s    = I_arm & ~I_disarm;
    assign count_en_s  = (state_q == ST_ARMED) || (state_q == ST_HOLDOFF);
    assign fire_next_s = fire_cnt_q + 8'd1;
    assign to_next_s   = to_cnt_q + TO_ONE;

    // Next-state, sequencing counters, and registered-output next values.
    always_comb begin
        state_d    = state_q;
        rs_cnt_d   = rs_cnt_q;
        to_cnt_d   = to_cnt_q;
        ho_cnt_d   = ho_cnt_q;
        fire_cnt_d = fire_cnt_q;
        sync_to_d  = sync_to_q;
        fire_s     = 1'b0;
        clear_s    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_ok_s) begin
                    clear_s    = 1'b1;
                    state_d    = ST_RESYNC;
                    rs_cnt_d   = 2'd0;
                    fire_cnt_d = 8'd0;
                    sync_to_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESYNC: begin
                if (rs_cnt_q == 2'd3) begin
                    state_d  = ST_WAIT_SYNC;
                    to_cnt_d = '0;
                end else begin
                    rs_cnt_d = rs_cnt_q + 2'd1;
                end
            end
            ST_WAIT_SYNC: begin
                if (I_synchronized) begin
                    state_d = ST_ARMED;
                end else if (to_next_s == {pTIMEOUT_WIDTH{1'b1}}) begin
                    to_cnt_d  = to_next_s;
                    sync_to_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    to_cnt_d = to_next_s;
                end
            end
            ST_ARMED: begin
                // A hit beats a simultaneous loss of sync.
                if (hit_s) begin
                    fire_s     = 1'b1;
                    fire_cnt_d = fire_next_s;
                    if ((I_trig_limit != 8'd0) && (fire_next_s == I_trig_limit)) begin
                        state_d = ST_DONE;
                    end else if (I_holdoff != 16'd0) begin
                        state_d  = ST_HOLDOFF;
                        ho_cnt_d = I_holdoff;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else if (!I_synchronized) begin
                    state_d  = ST_WAIT_SYNC;
                    to_cnt_d = '0;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_HOLDOFF: begin
                if (ho_cnt_q <= 16'd1) begin
                    ho_cnt_d = 16'd0;
                    state_d  = ST_ARMED;
                end else begin
                    ho_cnt_d = ho_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (I_disarm) begin
            state_d    = ST_IDLE;
            fire_s     = 1'b0;
            fire_cnt_d = fire_cnt_q;
        end else begin
            fire_s = fire_s;
        end

        trig_d       = I_trig_toggle ? (trig_q ^ fire_s) : fire_s;
        reset_sync_d = (state_d == ST_RESYNC);
        trig_en_d    = (state_d == ST_ARMED) || (state_d == ST_HOLDOFF);
    end

    // Per-rule saturating match counters; cleared on an accepted arm.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < pMATCH_RULES; i++) begin
            if (clear_s) begin
                cnt_d[i] = '0;
            end else if (count_en_s && I_matching_pattern[i]) begin
                cnt_d[i] = sat_inc(cnt_q[i]);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge trace_clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rs_cnt_q     <= 2'd0;
            to_cnt_q     <= '0;
            ho_cnt_q     <= 16'd0;
            fire_cnt_q   <= 8'd0;
            trig_q       <= 1'b0;
            reset_sync_q <= 1'b0;
            trig_en_q    <= 1'b0;
            sync_to_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rs_cnt_q     <= rs_cnt_d;
            to_cnt_q     <= to_cnt_d;
            ho_cnt_q     <= ho_cnt_d;
            fire_cnt_q   <= fire_cnt_d;
            trig_q       <= trig_d;
            reset_sync_q <= reset_sync_d;
            trig_en_q    <= trig_en_d;
            sync_to_q    <= sync_to_d;
            cnt_q        <= cnt_d;
        end
    end

    assign O_state             = state_q;
    assign O_trig              = trig_q;
    assign O_trace_reset_sync  = reset_sync_q;
    assign O_trace_trig_enable = trig_en_q;
    assign O_sync_timeout      = sync_to_q;
    assign O_trace_count       = cnt_q;

endmodule

// File: tb/tb_trace_trig_seq.sv
// Scoreboard bench for trace_trig_seq: expectations are queued as stimulus is driven
// and checked just after the following clock edge.
module tb_trace_trig_seq;

    localparam int R = 8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         arm, disarm, toggle, sync;
    logic [R-1:0] enable, match;
    logic [15:0]  holdoff;
    logic [7:0]   limit;
    logic         rs_o, ten_o, trig_o, to_o;
    logic [R*W-1:0] cnt_o;
    logic [2:0]   state_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    trace_trig_seq #(.pMATCH_RULES(R), .pCOUNT_WIDTH(W), .pTIMEOUT_WIDTH(4)) dut (
        .trace_clk          (clk),
        .reset_n            (reset_n),
        .I_arm              (arm),
        .I_disarm           (disarm),
        .I_pattern_enable   (enable),
        .I_trig_toggle      (toggle),
        .I_holdoff          (holdoff),
        .I_trig_limit       (limit),
        .I_synchronized     (sync),
        .I_matching_pattern (match),
        .O_trace_reset_sync (rs_o),
        .O_trace_trig_enable(ten_o),
        .O_trig             (trig_o),
        .O_trace_count      (cnt_o),
        .O_state            (state_o),
        .O_sync_timeout     (to_o)
    );

    always #5 clk = ~clk;

    localparam int S_STATE = 0, S_RS = 1, S_TEN = 2, S_TRIG = 3, S_TO = 4, S_CNT = 5;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_STATE: return {29'd0, state_o};
            S_RS:    return {31'd0, rs_o};
            S_TEN:   return {31'd0, ten_o};
            S_TRIG:  return {31'd0, trig_o};
            S_TO:    return {31'd0, to_o};
            default: return {24'd0, cnt_o[(sel-S_CNT)*W +: W]};
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic go_armed();
        arm = 1'b1;
        push("arm_state", S_STATE, 32'd1);
        push("arm_rs", S_RS, 32'd1);
        tick();
        arm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push("resync_state", S_STATE, 32'd1);
            push("resync_rs", S_RS, 32'd1);
            tick();
        end
        push("wait_state", S_STATE, 32'd2);
        push("wait_rs", S_RS, 32'd0);
        tick();
        push("armed_state", S_STATE, 32'd3);
        push("armed_ten", S_TEN, 32'd1);
        tick();
    endtask

    logic exp_trig;

    initial begin
        reset_n = 1'b0; arm = 1'b0; disarm = 1'b0; toggle = 1'b0; sync = 1'b1;
        enable = 8'h00; match = 8'h00; holdoff = 16'd0; limit = 8'd0;
        push("rst_state", S_STATE, 32'd0);
        push("rst_trig", S_TRIG, 32'd0);
        push("rst_ten", S_TEN, 32'd0);
        push("rst_rs", S_RS, 32'd0);
        push("rst_to", S_TO, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic arm, single pulse trigger with limit 1
        enable = 8'h01; holdoff = 16'd0; limit = 8'd1; toggle = 1'b0;
        go_armed();
        match = 8'h01;
        push("b_trig", S_TRIG, 32'd1);
        push("b_state", S_STATE, 32'd5);
        push("b_cnt0", S_CNT + 0, 32'd1);
        push("b_ten", S_TEN, 32'd0);
        tick();
        match = 8'h00;
        push("b_trig_low", S_TRIG, 32'd0);
        push("b_done", S_STATE, 32'd5);
        tick();

        // Holdoff 10, limit 3, toggle mode, rule 2 strobing every cycle
        enable = 8'h04; holdoff = 16'd10; limit = 8'd3; toggle = 1'b1;
        go_armed();
        match = 8'h04;
        exp_trig = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            exp_trig = ~exp_trig;
            push("h_trig", S_TRIG, {31'd0, exp_trig});
            push("h_state", S_STATE, (j == 3) ? 32'd5 : 32'd4);
            tick();
            if (j < 3) begin
                for (int k = 0; k < 9; k++) begin
                    push("h_hold_state", S_STATE, 32'd4);
                    push("h_hold_trig", S_TRIG, {31'd0, exp_trig});
                    tick();
                end
                push("h_rearm_state", S_STATE, 32'd3);
                tick();
            end
        end
        push("h_cnt2", S_CNT + 2, 32'd23);
        push("h_cnt0_clr", S_CNT + 0, 32'd0);
        push("h_done", S_STATE, 32'd5);
        tick();
        match = 8'h00;

        // Disabled rule 5 saturates, never triggers
        enable = 8'h01; holdoff = 16'd0; limit = 8'd0; toggle = 1'b0;
        go_armed();
        match = 8'h20;
        for (int i = 1; i <= 300; i++) begin
            if (i == 254) push("s_cnt5_254", S_CNT + 5, 32'd254);
            if (i == 300) begin
                push("s_cnt5_sat", S_CNT + 5, 32'd255);
                push("s_state", S_STATE, 32'd3);
                push("s_trig", S_TRIG, 32'd0);
            end
            tick();
        end
        match = 8'h00;

        // Back-to-back hits with holdoff 0 each fire
        match = 8'h01;
        for (int i = 0; i < 3; i++) begin
            push("bb_trig", S_TRIG, 32'd1);
            push("bb_state", S_STATE, 32'd3);
            tick();
        end
        match = 8'h00;
        push("bb_trig_low", S_TRIG, 32'd0);
        push("bb_cnt0", S_CNT + 0, 32'd3);
        tick();

        // Sync loss without hit, then with hit (hit wins)
        sync = 1'b0;
        push("sl_state", S_STATE, 32'd2);
        push("sl_ten", S_TEN, 32'd0);
        tick();
        sync = 1'b1;
        push("sl_rearm", S_STATE, 32'd3);
        push("sl_ten_back", S_TEN, 32'd1);
        tick();
        holdoff = 16'd5;
        sync = 1'b0;
        match = 8'h01;
        push("pr_trig", S_TRIG, 32'd1);
        push("pr_state", S_STATE, 32'd4);
        push("pr_ten", S_TEN, 32'd1);
        tick();
        sync = 1'b1;
        match = 8'h00;
        for (int k = 0; k < 4; k++) begin
            push("pr_hold", S_STATE, 32'd4);
            tick();
        end
        push("pr_back", S_STATE, 32'd3);
        push("pr_cnt0", S_CNT + 0, 32'd4);
        tick();

        // Disarm during holdoff retains counters
        match = 8'h01;
        push("d_hold", S_STATE, 32'd4);
        tick();
        match = 8'h00;
        disarm = 1'b1;
        push("d_idle", S_STATE, 32'd0);
        push("d_ten", S_TEN, 32'd0);
        push("d_cnt0", S_CNT + 0, 32'd5);
        push("d_cnt5", S_CNT + 5, 32'd255);
        tick();
        // Arm together with disarm: disarm wins
        arm = 1'b1;
        push("ad_idle", S_STATE, 32'd0);
        push("ad_cnt0", S_CNT + 0, 32'd5);
        tick();
        arm = 1'b0;
        disarm = 1'b0;

        // Sync timeout: 15 WAIT_SYNC cycles with 4-bit timeout
        sync = 1'b0;
        arm = 1'b1;
        push("t_arm_cnt0", S_CNT + 0, 32'd0);
        tick();
        arm = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        for (int k = 0; k < 15; k++) begin
            push("t_wait", S_STATE, 32'd2);
            push("t_flag_low", S_TO, 32'd0);
            tick();
        end
        push("t_idle", S_STATE, 32'd0);
        push("t_flag", S_TO, 32'd1);
        tick();
        push("t_flag_sticky", S_TO, 32'd1);
        tick();
        arm = 1'b1;
        push("t_clr_flag", S_TO, 32'd0);
        push("t_clr_state", S_STATE, 32'd1);
        tick();
        arm = 1'b0;
        disarm = 1'b1;
        tick();
        disarm = 1'b0;

        // Reset mid-ARMED
        sync = 1'b1; toggle = 1'b1; holdoff = 16'd0; limit = 8'd0; enable = 8'h01;
        go_armed();
        match = 8'h01;
        push("r_trig", S_TRIG, 32'd1);
        push("r_cnt0", S_CNT + 0, 32'd1);
        tick();
        match = 8'h00;
        reset_n = 1'b0;
        push("r_state", S_STATE, 32'd0);
        push("r_trig0", S_TRIG, 32'd0);
        push("r_ten", S_TEN, 32'd0);
        push("r_rs", S_RS, 32'd0);
        push("r_to", S_TO, 32'd0);
        push("r_cnt0_0", S_CNT + 0, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
